// File: rtl/tff_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tff_updown_counter_pkg
// Description : Shared definitions for the T flip-flop up/down counter:
//               direction encodings, limit-mode encodings and a parameter
//               range-check function used at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
package tff_updown_counter_pkg;

    // Direction encodings for up_dn
    localparam logic c_cnt_up = 1'b1;
    localparam logic c_cnt_dn = 1'b0;

    // Limit behaviour encodings for the SATURATE parameter
    localparam int c_sat_wrap = 0;
    localparam int c_sat_hold = 1;

    // Returns 1 when the parameter set describes a legal counter.
    function automatic bit f_params_ok(input int width, input int max_val,
                                       input int reset_val, input int saturate);
        longint l_full;
        l_full = (longint'(1) << width) - 1;
        return (width >= 2) && (max_val >= 1) && (longint'(max_val) <= l_full) &&
               (reset_val >= 0) && (reset_val <= max_val) &&
               ((saturate == c_sat_wrap) || (saturate == c_sat_hold));
    endfunction

endpackage : tff_updown_counter_pkg
`default_nettype wire

// File: rtl/tff_updown_counter_cell.sv
`default_nettype none
// ============================================================================
// Module      : tff_cell
// Description : One counter bit: a T flip-flop with asynchronous active-low
//               reset to a per-bit value and a synchronous override.
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset, q <= RESET_BIT
//   t        in  toggle request
//   sync_set in  synchronous override, takes priority over t
//   sync_val in  value loaded when sync_set is high
//   q        out registered bit
// Revision    : 1.0 - initial release
// ============================================================================
module tff_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic sync_set,
    input  logic sync_val,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_BIT;
        end else if (sync_set) begin
            q <= sync_val;
        end else begin
            q <= q ^ t;
        end
    end

endmodule : tff_cell
`default_nettype wire

// File: rtl/tff_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tff_updown_counter
// Description : Parametrised up/down counter built from a chain of T
//               flip-flop cells, with programmable modulus, load, clear,
//               wrap or saturate at the limits, terminal count and overflow.
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   en       in  count enable
//   up_dn    in  1 = count up, 0 = count down
//   load     in  synchronous load of load_val (clamped to MAX_VAL)
//   load_val in  value to load
//   clear    in  synchronous clear to 0 (beats load)
//   q        out current count
//   tc       out terminal count for the current direction (combinational)
//   ovf      out registered one-cycle pulse on a wrap or saturation hit
// Revision    : 1.0 - initial release
// ============================================================================
module tff_updown_counter
    import tff_updown_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = c_sat_wrap
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_rst = WIDTH'(RESET_VAL);

    if (!f_params_ok(WIDTH, MAX_VAL, RESET_VAL, SATURATE)) begin : g_param_err
        $error("tff_updown_counter: illegal WIDTH/MAX_VAL/RESET_VAL/SATURATE");
    end

    logic [WIDTH-1:0] w_t_step;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_sync_val;
    logic             w_sync_set;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_limit;
    logic             r_ovf;

    assign w_at_max   = (q == c_max);
    assign w_at_zero  = (q == '0);
    assign w_at_limit = (up_dn == c_cnt_up) ? w_at_max : w_at_zero;

    // Ripple toggle pattern of a binary counter: a bit flips when every
    // lower bit is all-ones (counting up) or all-zeros (counting down).
    for (genvar i = 0; i < WIDTH; i++) begin : g_step
        if (i == 0) begin : g_lsb
            assign w_t_step[i] = 1'b1;
        end else begin : g_upper
            assign w_t_step[i] = (up_dn == c_cnt_up) ? (&q[i-1:0]) : (~|q[i-1:0]);
        end
    end

    // At a limit the plain step pattern is wrong for a non-power-of-two
    // modulus, so the toggle vector is chosen to land exactly on the
    // opposite limit: XOR with q clears it, XOR of 0 with c_max sets it.
    always_comb begin
        w_t = '0;
        if (en) begin
            if (w_at_limit) begin
                if (SATURATE == c_sat_hold) begin
                    w_t = '0;
                end else if (up_dn == c_cnt_up) begin
                    w_t = q;
                end else begin
                    w_t = c_max;
                end
            end else begin
                w_t = w_t_step;
            end
        end
    end

    // clear and load share the synchronous override path; clear wins.
    always_comb begin
        w_sync_set = clear | load;
        w_sync_val = '0;
        if (!clear) begin
            w_sync_val = (load_val > c_max) ? c_max : load_val;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell #(
            .RESET_BIT (c_rst[i])
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .t        (w_t[i]),
            .sync_set (w_sync_set),
            .sync_val (w_sync_val[i]),
            .q        (q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= en & ~clear & ~load & w_at_limit;
        end
    end

    assign tc  = w_at_limit;
    assign ovf = r_ovf;

endmodule : tff_updown_counter
`default_nettype wire

// File: tb/tb_tff_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tff_updown_counter
// Description : Self-checking bench for tff_updown_counter. Three instances
//               share one stimulus stream: 4-bit mod-10 wrapping, 4-bit
//               mod-10 saturating and 4-bit mod-16 wrapping. A reference
//               model predicts each edge into a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_updown_counter;

    localparam int c_ndut = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            up_dn;
    logic            load;
    logic [3:0]      load_val;
    logic            clear;
    logic [2:0][3:0] q_a;
    logic [2:0]      tc_a;
    logic [2:0]      ovf_a;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance
    int   mx  [c_ndut] = '{9, 9, 15};
    int   sat [c_ndut] = '{0, 1, 0};
    int   m_q [c_ndut];
    logic [4:0] sb [$];   // {ovf, q} entries, pushed in instance order

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(4), .MAX_VAL(9),  .RESET_VAL(0), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear), .q(q_a[0]), .tc(tc_a[0]), .ovf(ovf_a[0]));
    tff_updown_counter #(.WIDTH(4), .MAX_VAL(9),  .RESET_VAL(0), .SATURATE(1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear), .q(q_a[1]), .tc(tc_a[1]), .ovf(ovf_a[1]));
    tff_updown_counter #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(0), .SATURATE(0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear), .q(q_a[2]), .tc(tc_a[2]), .ovf(ovf_a[2]));

    // Reference behaviour written arithmetically: {ovf, next q}
    function automatic logic [4:0] f_model(input int k);
        int nq;
        logic no;
        nq = m_q[k];
        no = 1'b0;
        if (clear) begin
            nq = 0;
        end else if (load) begin
            nq = (int'(load_val) > mx[k]) ? mx[k] : int'(load_val);
        end else if (en) begin
            if (up_dn) begin
                if (m_q[k] == mx[k]) begin
                    no = 1'b1;
                    nq = sat[k] ? mx[k] : 0;
                end else begin
                    nq = m_q[k] + 1;
                end
            end else begin
                if (m_q[k] == 0) begin
                    no = 1'b1;
                    nq = sat[k] ? 0 : mx[k];
                end else begin
                    nq = m_q[k] - 1;
                end
            end
        end
        return {no, 4'(nq)};
    endfunction

    function automatic logic f_tc(input int k);
        return up_dn ? (m_q[k] == mx[k]) : (m_q[k] == 0);
    endfunction

    // Predict the coming edge for every instance, then let it happen.
    task automatic push_and_step();
        logic [4:0] e;
        for (int k = 0; k < c_ndut; k++) begin
            e = f_model(k);
            sb.push_back(e);
            m_q[k] = int'(e[3:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_en, input logic i_up, input logic i_ld,
                         input logic [3:0] i_lv, input logic i_clr);
        @(negedge clk);
        en = i_en; up_dn = i_up; load = i_ld; load_val = i_lv; clear = i_clr;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        // Power-up reset state
        for (int k = 0; k < c_ndut; k++) begin
            n_checks++;
            if (q_a[k] !== 4'd0 || ovf_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_init dut%0d: q=%0d ovf=%b, need q=0 ovf=0", k, q_a[k], ovf_a[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < c_ndut; k++) m_q[k] = 0;
        drive(1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
        push_and_step();
        for (int k = 0; k < c_ndut; k++) begin
            e = sb.pop_front();
            n_checks++;
            if (q_a[k] !== e[3:0]) begin
                n_fail++;
                $display("FAIL reset_preload dut%0d: q=%0d, need %0d", k, q_a[k], e[3:0]);
            end
        end
        // Asynchronous assertion mid-cycle while counting is enabled
        en = 1'b1; load = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < c_ndut; k++) begin
            n_checks++;
            if (q_a[k] !== 4'd0 || ovf_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_async dut%0d: q=%0d ovf=%b, need q=0 ovf=0", k, q_a[k], ovf_a[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < c_ndut; k++) begin
            n_checks++;
            if (q_a[k] !== 4'd0 || ovf_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold dut%0d: q=%0d ovf=%b, need q=0 ovf=0", k, q_a[k], ovf_a[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < c_ndut; k++) m_q[k] = 0;
    endtask

    task automatic test_up_wrap();
        logic [4:0] e;
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_and_step();
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        for (int s = 0; s < 11; s++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
            #1;
            for (int k = 0; k < c_ndut; k++) begin
                n_checks++;
                if (tc_a[k] !== f_tc(k)) begin
                    n_fail++;
                    $display("FAIL up_tc dut%0d step%0d: tc=%b, need %b", k, s, tc_a[k], f_tc(k));
                end
            end
            push_and_step();
            for (int k = 0; k < c_ndut; k++) begin
                e = sb.pop_front();
                n_checks++;
                if (q_a[k] !== e[3:0] || ovf_a[k] !== e[4]) begin
                    n_fail++;
                    $display("FAIL up_count dut%0d step%0d: q=%0d ovf=%b, need q=%0d ovf=%b",
                             k, s, q_a[k], ovf_a[k], e[3:0], e[4]);
                end
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [4:0] e;
        drive(1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        push_and_step();
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            #1;
            for (int k = 0; k < c_ndut; k++) begin
                n_checks++;
                if (tc_a[k] !== f_tc(k)) begin
                    n_fail++;
                    $display("FAIL down_tc dut%0d step%0d: tc=%b, need %b", k, s, tc_a[k], f_tc(k));
                end
            end
            push_and_step();
            for (int k = 0; k < c_ndut; k++) begin
                e = sb.pop_front();
                n_checks++;
                if (q_a[k] !== e[3:0] || ovf_a[k] !== e[4]) begin
                    n_fail++;
                    $display("FAIL down_count dut%0d step%0d: q=%0d ovf=%b, need q=%0d ovf=%b",
                             k, s, q_a[k], ovf_a[k], e[3:0], e[4]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [4:0] e;
        logic       l_en;
        drive(1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
        push_and_step();
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        // Up from 7: 8,9,9,9,9 then enable dropped
        for (int s = 0; s < 6; s++) begin
            l_en = (s < 5);
            drive(l_en, 1'b1, 1'b0, 4'd0, 1'b0);
            push_and_step();
            for (int k = 0; k < c_ndut; k++) begin
                e = sb.pop_front();
                n_checks++;
                if (q_a[k] !== e[3:0] || ovf_a[k] !== e[4]) begin
                    n_fail++;
                    $display("FAIL saturate dut%0d step%0d: q=%0d ovf=%b, need q=%0d ovf=%b",
                             k, s, q_a[k], ovf_a[k], e[3:0], e[4]);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [4:0] e;
        logic [4:0] l_tab [5];
        // {en, load, clear, load_val[1:0]-index} encoded as separate fields below
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: drive(1'b1, 1'b1, 1'b1, 4'd15, 1'b0);  // clamp: 15 -> MAX_VAL
                1: drive(1'b1, 1'b1, 1'b1, 4'd6,  1'b1);  // clear beats load
                2: drive(1'b1, 1'b0, 1'b1, 4'd4,  1'b0);  // load 4 beats en
                3: drive(1'b0, 1'b1, 1'b0, 4'd0,  1'b0);  // en=0 holds
                default: drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);  // clear beats en
            endcase
            push_and_step();
            for (int k = 0; k < c_ndut; k++) begin
                e = sb.pop_front();
                l_tab[s] = e;
                n_checks++;
                if (q_a[k] !== e[3:0] || ovf_a[k] !== e[4]) begin
                    n_fail++;
                    $display("FAIL priority dut%0d step%0d: q=%0d ovf=%b, need q=%0d ovf=%b",
                             k, s, q_a[k], ovf_a[k], e[3:0], e[4]);
                end
            end
        end
    endtask

    task automatic test_full_modulus();
        logic [3:0] l_nxt;
        logic [4:0] e;
        drive(1'b0, 1'b1, 1'b1, 4'd14, 1'b0);
        push_and_step();
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        for (int s = 0; s < 3; s++) begin
            l_nxt = 4'(m_q[2] + 1);
            drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
            push_and_step();
            for (int b = 0; b < 4; b++) begin
                n_checks++;
                if (q_a[2][b] !== l_nxt[b]) begin
                    n_fail++;
                    $display("FAIL full_bit step%0d bit%0d: q=%b, need %b", s, b, q_a[2][b], l_nxt[b]);
                end
            end
            for (int k = 0; k < c_ndut; k++) begin
                e = sb.pop_front();
                n_checks++;
                if (ovf_a[k] !== e[4] || q_a[k] !== e[3:0]) begin
                    n_fail++;
                    $display("FAIL full_count dut%0d step%0d: q=%0d ovf=%b, need q=%0d ovf=%b",
                             k, s, q_a[k], ovf_a[k], e[3:0], e[4]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        logic       l_up;
        drive(1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
        push_and_step();
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
        // Direction flips on consecutive edges, including across zero
        for (int s = 0; s < 8; s++) begin
            l_up = (s % 3) == 0;
            drive(1'b1, l_up, 1'b0, 4'd0, 1'b0);
            push_and_step();
            for (int k = 0; k < c_ndut; k++) begin
                e = sb.pop_front();
                n_checks++;
                if (q_a[k] !== e[3:0] || ovf_a[k] !== e[4]) begin
                    n_fail++;
                    $display("FAIL back_to_back dut%0d step%0d: q=%0d ovf=%b, need q=%0d ovf=%b",
                             k, s, q_a[k], ovf_a[k], e[3:0], e[4]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; clear = 1'b0;
        #12;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_priority();
        test_full_modulus();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tff_updown_counter
`default_nettype wire
